// File: rtl/sensor_vote_pkg.sv
// Shared types and helpers for the K-of-N low-sensor voter.
// The popcount helper takes a 32-bit vector plus the number of live bits.
package sensor_vote_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    RELEASE = 2'd3
  } vote_state_e;

  localparam int unsigned MAX_SENSORS = 32;

  // Counts set bits in v[width-1:0]. Bits at or above width are ignored.
  function automatic logic [5:0] popcount(input logic [MAX_SENSORS-1:0] v,
                                          input int unsigned width);
    logic [5:0] c;
    c = '0;
    for (int unsigned i = 0; i < MAX_SENSORS; i++) begin
      if (i < width) c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/sensor_vote_monitor_popcount.sv
// Combinational masked low-count: counts sensors that are low and not masked.
// Kept as its own block so the adder tree can be exercised in isolation.
module sensor_popcount
  import sensor_vote_pkg::*;
#(
  parameter int N_SENSORS = 7,
  parameter int CNT_W     = $clog2(N_SENSORS + 1)
) (
  input  logic [N_SENSORS-1:0] sensors,
  input  logic [N_SENSORS-1:0] mask,
  output logic [CNT_W-1:0]     low_count
);

  logic [MAX_SENSORS-1:0] lows;

  assign lows      = MAX_SENSORS'(~sensors & ~mask);
  assign low_count = CNT_W'(popcount(lows, N_SENSORS));

endmodule

// File: rtl/sensor_vote_monitor.sv
// Registered K-of-N low-sensor voter with persistence filtering, release
// hysteresis, a sticky alarm and a saturating trip-event counter.
module sensor_vote_monitor
  import sensor_vote_pkg::*;
#(
  parameter  int N_SENSORS = 7,
  parameter  int THRESHOLD = 2,
  parameter  int PERSIST   = 4,
  parameter  int EVT_W     = 8,
  localparam int CNT_W     = $clog2(N_SENSORS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SENSORS-1:0] sensors,
  input  logic [N_SENSORS-1:0] mask,
  input  logic                 clear,
  output logic [CNT_W-1:0]     low_count,
  output logic                 f,
  output logic                 alarm_sticky,
  output logic [EVT_W-1:0]     trip_events
);

  localparam int PCNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERSIST - 1);
  localparam logic [EVT_W-1:0]  EVT_MAX   = '1;

  if (THRESHOLD < 1 || THRESHOLD > N_SENSORS || PERSIST < 1 ||
      N_SENSORS < 2 || N_SENSORS > 32) begin : g_param_err
    $error("sensor_vote_monitor: illegal N_SENSORS/THRESHOLD/PERSIST");
  end

  logic [N_SENSORS-1:0] sens_q;
  logic [N_SENSORS-1:0] mask_q;
  logic [CNT_W-1:0]     low_count_d;
  logic                 raw_trip;
  logic                 enter_alarm;
  vote_state_e          state;
  logic [PCNT_W-1:0]    pcnt;

  sensor_popcount #(
    .N_SENSORS(N_SENSORS),
    .CNT_W    (CNT_W)
  ) u_popcount (
    .sensors  (sens_q),
    .mask     (mask_q),
    .low_count(low_count_d)
  );

  // Two-stage pipeline: capture pins, then register the vote count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sens_q    <= '1;
      mask_q    <= '0;
      low_count <= '0;
    end else begin
      sens_q    <= sensors;
      mask_q    <= mask;
      low_count <= low_count_d;
    end
  end

  assign raw_trip = (low_count >= CNT_W'(THRESHOLD));

  // A fresh alarm (f rising); RELEASE->ALARM keeps f high and is not a new trip.
  assign enter_alarm = raw_trip &&
                       ((state == IDLE && PERSIST == 1) ||
                        (state == PENDING && pcnt == PCNT_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt  <= '0;
      f     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (raw_trip) begin
            if (PERSIST == 1) begin
              state <= ALARM;
              f     <= 1'b1;
            end else begin
              state <= PENDING;
              pcnt  <= PCNT_W'(1);
            end
          end
        end
        PENDING: begin
          if (!raw_trip) begin
            state <= IDLE;
            pcnt  <= '0;
          end else if (pcnt == PCNT_LAST) begin
            state <= ALARM;
            pcnt  <= '0;
            f     <= 1'b1;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        ALARM: begin
          if (!raw_trip) begin
            if (PERSIST == 1) begin
              state <= IDLE;
              f     <= 1'b0;
            end else begin
              state <= RELEASE;
              pcnt  <= PCNT_W'(1);
            end
          end
        end
        RELEASE: begin
          if (raw_trip) begin
            state <= ALARM;
            pcnt  <= '0;
          end else if (pcnt == PCNT_LAST) begin
            state <= IDLE;
            pcnt  <= '0;
            f     <= 1'b0;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          pcnt  <= '0;
          f     <= 1'b0;
        end
      endcase
    end
  end

  // Set beats clear; clear together with a new trip leaves a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_sticky <= 1'b0;
      trip_events  <= '0;
    end else begin
      if (enter_alarm)  alarm_sticky <= 1'b1;
      else if (clear)   alarm_sticky <= 1'b0;

      if (clear)                                  trip_events <= enter_alarm ? EVT_W'(1) : '0;
      else if (enter_alarm && trip_events != EVT_MAX) trip_events <= trip_events + EVT_W'(1);
    end
  end

endmodule

// File: tb/tb_sensor_vote_monitor.sv
// Directed bench for sensor_vote_monitor: default instance (7/2/4/8) plus a
// PERSIST=1, EVT_W=2 instance for counter saturation and clear/set races.
module tb_sensor_vote_monitor;

  logic       clk;
  logic       rst_n;

  logic [6:0] s1, m1;
  logic       c1;
  logic [2:0] lc1;
  logic       f1, st1;
  logic [7:0] ev1;

  logic [6:0] s2, m2;
  logic       c2;
  logic [2:0] lc2;
  logic       f2, st2;
  logic [1:0] ev2;

  int total  = 0;
  int passed = 0;

  sensor_vote_monitor #(
    .N_SENSORS(7), .THRESHOLD(2), .PERSIST(4), .EVT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .sensors(s1), .mask(m1), .clear(c1),
    .low_count(lc1), .f(f1), .alarm_sticky(st1), .trip_events(ev1)
  );

  sensor_vote_monitor #(
    .N_SENSORS(7), .THRESHOLD(2), .PERSIST(1), .EVT_W(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .sensors(s2), .mask(m2), .clear(c2),
    .low_count(lc2), .f(f2), .alarm_sticky(st2), .trip_events(ev2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 7'h7F; m1 = 7'h00; c1 = 1'b0;
    s2 = 7'h7F; m2 = 7'h00; c2 = 1'b0;
    tick(3);
    chk("rst_low_count", 32'(lc1), 0);
    chk("rst_f", 32'(f1), 0);
    chk("rst_sticky", 32'(st1), 0);
    chk("rst_events", 32'(ev1), 0);
    rst_n = 1'b1;

    // 1: all healthy for 20 cycles
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk($sformatf("idle_lc_%0d", i), 32'(lc1), 0);
      chk($sformatf("idle_f_%0d", i), 32'(f1), 0);
      chk($sformatf("idle_ev_%0d", i), 32'(ev1), 0);
    end

    // 2: two low sensors held -> alarm after E+5
    s1 = 7'h7C;
    tick(1);
    chk("trip_lc_at_E", 32'(lc1), 0);
    tick(1);
    chk("trip_lc_at_E1", 32'(lc1), 2);
    tick(3);
    chk("trip_f_at_E4", 32'(f1), 0);
    tick(1);
    chk("trip_f_at_E5", 32'(f1), 1);
    chk("trip_ev", 32'(ev1), 1);
    chk("trip_sticky", 32'(st1), 1);

    // 4: short dropout keeps alarm, no new event
    s1 = 7'h7F;
    tick(2);
    s1 = 7'h7C;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("dropout_f_%0d", i), 32'(f1), 1);
    end
    chk("dropout_ev", 32'(ev1), 1);

    // Release after exactly PERSIST false evaluations
    s1 = 7'h7F;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      chk($sformatf("release_f_hold_%0d", i), 32'(f1), 1);
    end
    tick(1);
    chk("release_f_drop", 32'(f1), 0);
    chk("release_sticky_held", 32'(st1), 1);

    c1 = 1'b1;
    tick(1);
    c1 = 1'b0;
    chk("clear_sticky", 32'(st1), 0);
    chk("clear_ev", 32'(ev1), 0);

    // 3: trip only PERSIST-1 evaluations long
    s1 = 7'h7C;
    tick(3);
    s1 = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk($sformatf("glitch_f_%0d", i), 32'(f1), 0);
    end
    chk("glitch_ev", 32'(ev1), 0);
    chk("glitch_sticky", 32'(st1), 0);

    // 5: masking
    m1 = 7'h01;
    s1 = 7'h7C;
    tick(2);
    chk("mask_lc", 32'(lc1), 1);
    tick(8);
    chk("mask_f", 32'(f1), 0);
    m1 = 7'h00;
    tick(1);
    tick(1);
    chk("unmask_lc", 32'(lc1), 2);
    tick(3);
    chk("unmask_f_E4", 32'(f1), 0);
    tick(1);
    chk("unmask_f_E5", 32'(f1), 1);
    chk("unmask_ev", 32'(ev1), 1);
    m1 = 7'h7F;
    s1 = 7'h00;
    tick(2);
    chk("allmask_lc", 32'(lc1), 0);
    tick(6);
    chk("allmask_f_released", 32'(f1), 0);
    tick(5);
    chk("allmask_f_stays", 32'(f1), 0);
    chk("allmask_ev", 32'(ev1), 1);

    // 6: asynchronous reset mid-alarm, then restart from IDLE
    m1 = 7'h00;
    s1 = 7'h7C;
    tick(8);
    chk("pre_reset_f", 32'(f1), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_f", 32'(f1), 0);
    chk("async_rst_lc", 32'(lc1), 0);
    chk("async_rst_ev", 32'(ev1), 0);
    chk("async_rst_sticky", 32'(st1), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("restart_lc_R1", 32'(lc1), 0);
    tick(1);
    chk("restart_lc_R2", 32'(lc1), 2);
    tick(3);
    chk("restart_f_R5", 32'(f1), 0);
    tick(1);
    chk("restart_f_R6", 32'(f1), 1);
    chk("restart_ev", 32'(ev1), 1);

    // Saturation with EVT_W=2, PERSIST=1
    for (int i = 1; i <= 5; i++) begin
      s2 = 7'h7C;
      tick(3);
      chk($sformatf("sat_f_on_%0d", i), 32'(f2), 1);
      chk($sformatf("sat_ev_%0d", i), 32'(ev2), (i > 3) ? 3 : i);
      s2 = 7'h7F;
      tick(3);
      chk($sformatf("sat_f_off_%0d", i), 32'(f2), 0);
    end
    chk("sat_sticky", 32'(st2), 1);

    // clear concurrent with a new trip: sticky stays set, count becomes 1
    s2 = 7'h7C;
    tick(2);
    c2 = 1'b1;
    tick(1);
    c2 = 1'b0;
    chk("race_f", 32'(f2), 1);
    chk("race_sticky", 32'(st2), 1);
    chk("race_ev", 32'(ev2), 1);

    s2 = 7'h7F;
    tick(3);
    c2 = 1'b1;
    tick(1);
    c2 = 1'b0;
    chk("plain_clear_sticky", 32'(st2), 0);
    chk("plain_clear_ev", 32'(ev2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sensor_vote_monitor.md
Name: sensor_vote_monitor

Overview:
- Parametrised N-sensor "K-of-N low" fault voter. It is the registered, generalised successor of the fixed seven-sensor any-two-low SOP detector.
- Adds per-sensor masking, a configurable threshold, persistence filtering with release hysteresis, a sticky alarm and a trip-event counter.
- Sits between raw sensor pins and the supervisory/alarm logic.

Parameters:
- N_SENSORS, 7: number of sensor inputs. Legal range is 2..32.
- THRESHOLD, 2: minimum count of unmasked low sensors that constitutes a raw trip. Legal range is 1..N_SENSORS.
- PERSIST, 4: consecutive evaluation cycles required both to assert and to release the alarm. Must be at least 1.
- EVT_W, 8: width of the trip-event counter.
- CNT_W, $clog2(N_SENSORS+1): derived width of the low-count value. Not user-set.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sensors  in  N_SENSORS  sensor levels; 0 means faulted/low.
- mask  in  N_SENSORS  1 excludes that sensor from the vote.
- clear  in  1  synchronous clear of alarm_sticky and trip_events.
- low_count  out  CNT_W  registered count of unmasked low sensors.
- f  out  1  filtered alarm.
- alarm_sticky  out  1  set by f, held until clear.
- trip_events  out  EVT_W  saturating count of alarm assertions.

Behaviour:
- Reset: rst_n low asynchronously forces all of the following, regardless of clk. Deassertion is taken synchronously by design.
  - sens_q and mask_q = all ones / all zeros.
  - low_count = 0.
  - FSM = IDLE, persist counter = 0.
  - f = 0, alarm_sticky = 0, trip_events = 0.
- Stage 1: at edge E, sensors → sens_q and mask → mask_q.
- Stage 2: at edge E+1, low_count = popcount(~sens_q & ~mask_q). raw_trip = (low_count >= THRESHOLD), combinational from the low_count register.
- FSM: evaluated every edge from E+2 onward. State encoding is IDLE, PENDING, ALARM, RELEASE; pcnt is the persist counter.
  - IDLE: f=0.
    - raw_trip with PERSIST==1 → ALARM.
    - raw_trip otherwise → PENDING, pcnt=1.
  - PENDING: f=0.
    - raw_trip and pcnt+1==PERSIST → ALARM.
    - raw_trip otherwise → pcnt++.
    - !raw_trip → IDLE, pcnt=0.
  - ALARM: f=1.
    - !raw_trip with PERSIST==1 → IDLE.
    - !raw_trip otherwise → RELEASE, pcnt=1.
  - RELEASE: f=1.
    - !raw_trip and pcnt+1==PERSIST → IDLE.
    - !raw_trip otherwise → pcnt++.
    - raw_trip → ALARM, pcnt=0.
- f is a registered decode of state (ALARM or RELEASE).
- Latency:
  - A trip condition present at sampling edge E and held asserts f after edge E+1+PERSIST.
  - Release is symmetric: f drops PERSIST evaluations after raw_trip goes false.
- Glitch behaviour: a raw_trip shorter than PERSIST evaluations never asserts f. A dropout shorter than PERSIST evaluations never deasserts f.
- Sticky alarm: alarm_sticky sets on the edge where f becomes 1. If clear and set occur in the same cycle, set wins.
- Trip events: trip_events increments on every IDLE/PENDING→ALARM transition and saturates at 2^EVT_W−1. If clear and an increment occur together, the result is 1.
- Mask: a masked sensor never counts, whatever its level. If every sensor is masked, low_count=0 and f can never assert.
- Mask changes follow the same two-edge pipeline as sensors.
- Reset mid-alarm: f and counters drop immediately. After reset release, the vote restarts from IDLE.
- Illegal parameters (THRESHOLD>N_SENSORS, THRESHOLD==0, PERSIST==0): elaboration-time error via generate-if $error.

Decomposition:
- Package sensor_vote_pkg holds:
  - the state enum type (IDLE, PENDING, ALARM, RELEASE);
  - the popcount function, parametrised by width.
- One natural sub-module: sensor_popcount, a combinational masked low-count of width N_SENSORS.
  - It keeps the adder tree separately testable.
  - The top registers its output.

Test Plan:
All scenarios use N=7, THRESHOLD=2, PERSIST=4 unless stated.
1. Reset release, all sensors=7'h7F → low_count=0, f=0, trip_events=0 for 20 cycles.
2. Sensors=7'h7C held from edge E → low_count=2 after E+1; f=1 after edge E+5; trip_events=1; alarm_sticky=1.
3. Sensors=7'h7C for 3 cycles, then 7'h7F → f stays 0 and trip_events stays 0.
4. Alarm active, sensors return to 7'h7F for 2 cycles, then 7'h7C again → f stays 1 (RELEASE→ALARM) and trip_events is unchanged.
5. Sensors=7'h7C with mask=7'h01 → low_count=1, f never asserts. Then mask=0 → alarm follows after E+5 timing. Finally, all-masked with sensors=0 → low_count=0.
6. Alarm active, rst_n pulled low mid-cycle → f, low_count and trip_events are 0 before the next clk edge. Then, with EVT_W=2 and 5 trips, trip_events saturates at 3. clear concurrent with a set gives alarm_sticky=1.
